// File: rtl/trace_writer.sv
// Write-side sequencer for the per-column trace buffer: one column per handshake, written only inside the VBLANK window.
// Optional frame checksum is enabled by defining TRACE_WRITER_CHECKSUM_EN.
module trace_writer #(
  parameter int COLUMNS    = 640,
  parameter int COL_W      = 10,
  parameter int HEIGHT_W   = 8,
  parameter int MAX_HEIGHT = 240
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                frame_start,
  input  logic                enable,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_side,
  input  logic [HEIGHT_W-1:0] in_height,
  output logic [COL_W-1:0]    buf_addr,
  output logic                buf_we,
  output logic                buf_side,
  output logic [HEIGHT_W-1:0] buf_height,
  output logic                frame_done,
  output logic                incomplete,
  output logic [COL_W-1:0]    col_count,
  output logic [15:0]         checksum
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [COL_W-1:0]    LAST_COL = COL_W'(COLUMNS - 1);
  localparam logic [HEIGHT_W-1:0] MAX_H    = HEIGHT_W'(MAX_HEIGHT);

  logic [1:0]          state_reg;
  logic [COL_W-1:0]    addr_reg;
  logic [COL_W-1:0]    col_count_reg;
  logic [COL_W-1:0]    last_addr_reg;
  logic                pend_reg;
  logic                last_taken_reg;
  logic                incomplete_reg;
  logic                side_reg;
  logic [HEIGHT_W-1:0] height_reg;
  logic [HEIGHT_W-1:0] height_clamped;
  logic                handshake;
  logic                in_write;

  assign in_write       = (state_reg == S_WRITE);
  assign in_ready       = in_write && enable && !last_taken_reg;
  assign handshake      = in_valid && in_ready && !frame_start;
  assign height_clamped = (in_height > MAX_H) ? MAX_H : in_height;

  // Writes are in order, so the column being written is the count of columns already written.
  assign buf_we     = in_write && pend_reg && enable;
  assign buf_addr   = buf_we ? col_count_reg : last_addr_reg;
  assign frame_done = buf_we && (col_count_reg == LAST_COL);
  assign buf_side   = side_reg;
  assign buf_height = height_reg;
  assign incomplete = incomplete_reg;
  assign col_count  = col_count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= S_IDLE;
      addr_reg       <= '0;
      col_count_reg  <= '0;
      last_addr_reg  <= '0;
      pend_reg       <= 1'b0;
      last_taken_reg <= 1'b0;
      incomplete_reg <= 1'b0;
      side_reg       <= 1'b0;
      height_reg     <= '0;
    end else begin
      incomplete_reg <= 1'b0;
      if (frame_start) begin
        state_reg      <= S_ARMED;
        addr_reg       <= '0;
        col_count_reg  <= '0;
        pend_reg       <= 1'b0;
        last_taken_reg <= 1'b0;
      end else begin
        case (state_reg)
          S_ARMED: if (enable) state_reg <= S_WRITE;
          S_WRITE: begin
            if (!enable) begin
              // Window closed early: any pending capture is dropped.
              state_reg      <= S_IDLE;
              pend_reg       <= 1'b0;
              incomplete_reg <= 1'b1;
            end else begin
              pend_reg <= handshake;
              if (handshake) begin
                side_reg   <= in_side;
                height_reg <= height_clamped;
                addr_reg   <= addr_reg + 1'b1;
                if (addr_reg == LAST_COL) last_taken_reg <= 1'b1;
              end
              if (buf_we) begin
                col_count_reg <= col_count_reg + 1'b1;
                last_addr_reg <= col_count_reg;
                if (frame_done) state_reg <= S_DONE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef TRACE_WRITER_CHECKSUM_EN
  logic [15:0] sum_reg;
  logic [15:0] checksum_reg;
  logic [15:0] word;

  assign word     = 16'({side_reg, height_reg});
  assign checksum = frame_done ? (sum_reg + word) : checksum_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_reg      <= '0;
      checksum_reg <= '0;
    end else begin
      if (frame_start) sum_reg <= '0;
      else if (buf_we) sum_reg <= sum_reg + word;
      if (frame_done) checksum_reg <= sum_reg + word;
    end
  end
`else
  assign checksum = 16'd0;
`endif

endmodule

// File: tb/tb_trace_writer.sv
// Directed bench for trace_writer: cycle-by-cycle vector table plus hand sequences for abort, async reset and checksum.
module tb_trace_writer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_start = 1'b0, enable = 1'b0, in_valid = 1'b0, in_side = 1'b0;
  logic [7:0]  in_height = '0;
  logic        in_ready, buf_we, buf_side, frame_done, incomplete;
  logic [9:0]  buf_addr, col_count;
  logic [7:0]  buf_height;
  logic [15:0] checksum;

  logic        c_fs = 1'b0, c_en = 1'b0, c_v = 1'b0, c_s = 1'b0;
  logic [7:0]  c_h = '0;
  logic        c_rdy, c_we, c_bs, c_fd, c_inc;
  logic [9:0]  c_addr, c_cnt;
  logic [7:0]  c_bh;
  logic [15:0] c_sum;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  trace_writer #(.COLUMNS(8), .COL_W(10), .HEIGHT_W(8), .MAX_HEIGHT(240)) dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready), .in_side(in_side), .in_height(in_height),
    .buf_addr(buf_addr), .buf_we(buf_we), .buf_side(buf_side), .buf_height(buf_height),
    .frame_done(frame_done), .incomplete(incomplete), .col_count(col_count), .checksum(checksum)
  );

  trace_writer #(.COLUMNS(4), .COL_W(10), .HEIGHT_W(8), .MAX_HEIGHT(240)) dut4 (
    .clk(clk), .reset_n(reset_n), .frame_start(c_fs), .enable(c_en),
    .in_valid(c_v), .in_ready(c_rdy), .in_side(c_s), .in_height(c_h),
    .buf_addr(c_addr), .buf_we(c_we), .buf_side(c_bs), .buf_height(c_bh),
    .frame_done(c_fd), .incomplete(c_inc), .col_count(c_cnt), .checksum(c_sum)
  );

  typedef struct {
    logic fs, en, v, s;
    logic [7:0] h;
    logic rdy, we;
    logic [9:0] addr;
    logic bs;
    logic [7:0] bh;
    logic fd, inc;
    logic [9:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic fs, en, v, s, input logic [7:0] h,
                     input logic rdy, we, input logic [9:0] addr, input logic bs,
                     input logic [7:0] bh, input logic fd, inc, input logic [9:0] cnt);
    vec_t r;
    r.fs = fs; r.en = en; r.v = v; r.s = s; r.h = h;
    r.rdy = rdy; r.we = we; r.addr = addr; r.bs = bs; r.bh = bh;
    r.fd = fd; r.inc = inc; r.cnt = cnt;
    tbl.push_back(r);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic cyc(input logic fs, en, v, s, input logic [7:0] h);
    @(negedge clk);
    frame_start = fs; enable = en; in_valid = v; in_side = s; in_height = h;
    #2;
  endtask

  initial begin
    logic [32:0] act_v, exp_v;
    int idx;
    bit seen;
    logic [15:0] exp_sum;

    // rows: inputs (fs en v side height) -> outputs (rdy we addr side height done inc count)
    add(1,0,0,0,  0,  0,0,0,0,  0,0,0,0);
    add(0,1,1,0, 10,  0,0,0,0,  0,0,0,0);
    add(0,1,1,0, 10,  1,0,0,0,  0,0,0,0);
    add(0,1,1,1, 11,  1,1,0,0, 10,0,0,0);
    add(0,1,1,0, 12,  1,1,1,1, 11,0,0,1);
    add(0,1,1,1, 13,  1,1,2,0, 12,0,0,2);
    add(0,1,1,0, 14,  1,1,3,1, 13,0,0,3);
    add(0,1,1,1, 15,  1,1,4,0, 14,0,0,4);
    add(0,1,1,0, 16,  1,1,5,1, 15,0,0,5);
    add(0,1,1,1, 17,  1,1,6,0, 16,0,0,6);
    add(0,1,1,0, 99,  0,1,7,1, 17,1,0,7);
    add(0,1,1,0, 99,  0,0,7,1, 17,0,0,8);
    add(1,1,1,1,255,  0,0,7,1, 17,0,0,8);
    add(0,1,1,1,255,  0,0,7,1, 17,0,0,0);
    add(0,1,1,1,255,  1,0,7,1, 17,0,0,0);
    add(0,1,1,0,  0,  1,1,0,1,240,0,0,0);
    add(0,1,1,1,240,  1,1,1,0,  0,0,0,1);
    add(0,1,1,0,241,  1,1,2,1,240,0,0,2);
    add(0,1,1,1,  7,  1,1,3,0,240,0,0,3);
    add(0,1,1,0,  9,  1,1,4,1,  7,0,0,4);
    add(0,0,1,0,  9,  0,0,4,0,  9,0,0,5);
    add(0,1,1,0,  9,  0,0,4,0,  9,0,1,5);
    add(0,1,1,0,  9,  0,0,4,0,  9,0,0,5);

    // reset state with inputs active
    enable = 1'b1; in_valid = 1'b1; in_height = 8'd33;
    @(negedge clk); #2;
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_we_addr", 64'({buf_we, buf_addr}), 64'd0);
    chk("rst_side_h", 64'({buf_side, buf_height}), 64'd0);
    chk("rst_pulses_cnt", 64'({frame_done, incomplete, col_count}), 64'd0);
    chk("rst_checksum", 64'(checksum), 64'd0);
    @(negedge clk);
    enable = 1'b0; in_valid = 1'b0; in_height = '0;
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      cyc(tbl[i].fs, tbl[i].en, tbl[i].v, tbl[i].s, tbl[i].h);
      act_v = {in_ready, buf_we, buf_addr, buf_side, buf_height, frame_done, incomplete, col_count};
      exp_v = {tbl[i].rdy, tbl[i].we, tbl[i].addr, tbl[i].bs, tbl[i].bh, tbl[i].fd, tbl[i].inc, tbl[i].cnt};
      chk($sformatf("row%0d", i), 64'(act_v), 64'(exp_v));
    end

    // frame_start collides with the handshake for column 3
    cyc(1,1,1,0,0);
    cyc(0,1,1,0,20);
    cyc(0,1,1,0,20);
    cyc(0,1,1,0,21);
    cyc(0,1,1,0,22);
    cyc(1,1,1,0,23);
    cyc(0,1,1,1,50);
    chk("abort_we", 64'(buf_we), 64'd0);
    chk("abort_cnt", 64'(col_count), 64'd0);
    chk("abort_ignored_h", 64'(buf_height), 64'd22);
    cyc(0,1,1,1,50);
    chk("restart_ready", 64'(in_ready), 64'd1);
    cyc(0,1,0,0,0);
    chk("restart_write", 64'({buf_we, buf_addr, buf_side, buf_height, col_count}),
        64'({1'b1, 10'd0, 1'b1, 8'd50, 10'd0}));

    // asynchronous reset between edges while writing
    cyc(1,1,1,0,5);
    cyc(0,1,1,0,5);
    cyc(0,1,1,0,6);
    cyc(0,1,1,0,7);
    cyc(0,1,1,0,8);
    chk("pre_rst_we_cnt", 64'({buf_we, col_count}), 64'({1'b1, 10'd1}));
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_we", 64'(buf_we), 64'd0);
    chk("async_rst_ready", 64'(in_ready), 64'd0);
    chk("async_rst_cnt", 64'(col_count), 64'd0);
    @(negedge clk);
    frame_start = 1'b0; enable = 1'b0; in_valid = 1'b0;
    reset_n = 1'b1;

    // four-column frame for the checksum
`ifdef TRACE_WRITER_CHECKSUM_EN
    exp_sum = 16'd522;
`else
    exp_sum = 16'd0;
`endif
    @(negedge clk);
    c_fs = 1'b1; c_en = 1'b1;
    @(negedge clk);
    c_fs = 1'b0;
    idx = 0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      c_v = (idx < 4);
      c_s = idx[0];
      c_h = 8'(idx + 1);
      #2;
      if (c_fd) begin
        seen = 1'b1;
        chk("cks_at_done", 64'(c_sum), 64'(exp_sum));
        chk("cks_done_addr", 64'(c_addr), 64'd3);
      end
      if (c_rdy && c_v) idx++;
    end
    if (!seen) chk("cks_frame_done_seen", 64'd0, 64'd1);
    @(negedge clk);
    c_v = 1'b0;
    #2;
    chk("cks_hold", 64'({c_sum, c_rdy, c_we}), 64'({exp_sum, 1'b0, 1'b0}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
